// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_WIDTH registers with byte-lane writes.
// Independent AW/W acceptance in either order, single-cycle commit, SLVERR outside the map.
module axi_lite_regbank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BL = $clog2(NB);
  localparam int IW = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;

  // In range iff every bit above the decoded index is zero, so high bits never alias.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (BL + IW)) == '0;
  endfunction

  // Readies depend only on internal state (and reset), never on the same channel's valid.
  assign awready = !areset && !aw_held && !bvalid;
  assign wready  = !areset && !w_held  && !bvalid;
  assign arready = !areset && (!rvalid || rready);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    wr_addr = awaddr;
    wr_data = wdata;
    wr_strb = wstrb;
    if (aw_held) wr_addr = aw_addr_q;
    if (w_held) begin
      wr_data = w_data_q;
      wr_strb = w_strb_q;
    end
  end

  assign commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok  = addr_in_range(wr_addr);
  assign rd_ok  = addr_in_range(araddr);
  assign wr_idx = wr_addr[BL +: IW];
  assign rd_idx = araddr[BL +: IW];

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  // NOTE: the register file is reset explicitly because software relies on zeros after
  // reset; this keeps it as flops rather than an inferred RAM.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Reads sample regs before any same-edge commit lands, returning the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? regs[rd_idx] : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed self-checking bench for axi_lite_regbank (default parameters: 32-bit, 16 regs).
module tb_axi_lite_regbank;

  logic        aclk;
  logic        areset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  axi_lite_regbank dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Full write, bready assumed high; returns the response seen one cycle after the handshake.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    @(negedge aclk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL write_accept_timeout awready=%b wready=%b need 1 1", awready, wready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL write_resp_timeout bvalid=%b need 1", bvalid);
    end
    resp = bresp;
  endtask

  // Single read with rready high; returns data/resp and extra cycles waited for rvalid.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    int n;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL read_accept_timeout arready=%b need 1", arready);
    end
    @(negedge aclk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin @(negedge aclk); lat++; end
    d = rdata;
    resp = rresp;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_readies got %b need 000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      errors++; $display("FAIL reset_valids got %b need 000000", {bvalid, rvalid, bresp, rresp});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h need 00000000", rdata);
    end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL post_reset_readies got %b need 111", {awready, wready, arready});
    end
  endtask

  task automatic test_read_default();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(32'h0C, d, r, lat);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL read_latency got %0d need 0", lat); end
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL read_default got %h/%b need 00000000/00", d, r);
    end
    @(negedge aclk);
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %b need 0", rvalid); end
  endtask

  task automatic test_split_write();
    logic [31:0] d; logic [1:0] r; int lat;
    @(negedge aclk);
    awaddr = 32'h08; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (awready !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b1) begin
      errors++; $display("FAIL aw_held_state got aw=%b b=%b w=%b need 0 0 1", awready, bvalid, wready);
    end
    repeat (2) @(negedge aclk);
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL split_write_resp got %b/%b need 1/00", bvalid, bresp);
    end
    do_read(32'h08, d, r, lat);
    checks++;
    if (d !== 32'hA5A5_A5A5 || r !== 2'b00) begin
      errors++; $display("FAIL split_write_read got %h/%b need a5a5a5a5/00", d, r);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h0C, 32'hFFFF_FFFF, 4'hF, r);
    do_write(32'h0C, 32'h1234_5678, 4'b0101, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strobe_resp got %b need 00", r); end
    do_read(32'h0C, d, r, lat);
    checks++;
    if (d !== 32'hFF34_FF78) begin errors++; $display("FAIL strobe_read got %h need ff34ff78", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h40, 32'hDEAD_BEEF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_write_resp got %b need 10", r); end
    do_read(32'h00, d, r, lat);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL oor_no_alias_reg0 got %h need 00000000", d); end
    do_read(32'h40, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL oor_read got %h/%b need 00000000/10", d, r);
    end
  endtask

  task automatic test_zero_strobe();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h0C, 32'h0000_0000, 4'h0, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL zero_strobe_resp got %b need 00", r); end
    do_read(32'h0C, d, r, lat);
    checks++;
    if (d !== 32'hFF34_FF78) begin errors++; $display("FAIL zero_strobe_data got %h need ff34ff78", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exps [4];
    logic [1:0] r;
    bready = 1'b0;
    @(negedge aclk);
    awaddr = 32'h14; wdata = 32'h33; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awaddr = 32'h10; wdata = 32'h77;
    r = bresp;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bvalid !== 1'b1 || bresp !== r || r !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL b_stall cycle %0d got bv=%b br=%b aw=%b w=%b need 1 00 0 0",
                 k, bvalid, bresp, awready, wready);
      end
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++; $display("FAIL b_release got bv=%b aw=%b w=%b need 0 1 1", bvalid, awready, wready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL second_write_resp got %b need 1", bvalid); end

    addrs[0] = 32'h08; addrs[1] = 32'h0C; addrs[2] = 32'h10; addrs[3] = 32'h14;
    exps[0] = 32'hA5A5_A5A5; exps[1] = 32'hFF34_FF78; exps[2] = 32'h77; exps[3] = 32'h33;
    @(negedge aclk);
    araddr = addrs[0]; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arready !== 1'b1) begin errors++; $display("FAIL b2b_arready %0d got %b need 1", i, arready); end
      @(negedge aclk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== exps[i]) begin
        errors++; $display("FAIL b2b_read %0d got %b/%h need 1/%h", i, rvalid, rdata, exps[i]);
      end
      if (i < 3) araddr = addrs[i+1];
      else arvalid = 1'b0;
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h04, 32'h11, 4'hF, r);
    @(negedge aclk);
    awaddr = 32'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h11 || bvalid !== 1'b1) begin
      errors++; $display("FAIL collision_old got rv=%b %h bv=%b need 1 00000011 1", rvalid, rdata, bvalid);
    end
    do_read(32'h04, d, r, lat);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL collision_new got %h need 00000055", d); end
  endtask

  task automatic test_alias();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0004, 32'h99, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL alias_write_resp got %b need 10", r); end
    do_read(32'h0001_0004, d, r, lat);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL alias_read got %h/%b need 00000000/10", d, r);
    end
    do_read(32'h04, d, r, lat);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL alias_untouched got %h need 00000055", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    rready = 1'b0;
    @(negedge aclk);
    araddr = 32'h0C; arvalid = 1'b1; awaddr = 32'h18; awvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if ({rvalid, bvalid, arready, awready} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_state got %b need 0000", {rvalid, bvalid, arready, awready});
    end
    areset = 1'b0; rready = 1'b1;
    @(negedge aclk);
    wdata = 32'hAB; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_aw_discard got bv=%b w=%b need 0 0", bvalid, wready);
    end
    awaddr = 32'h1C; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL mid_reset_w_then_aw got %b/%b need 1/00", bvalid, bresp);
    end
    do_read(32'h18, d, r, lat);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_no_partial got %h need 00000000", d); end
    do_read(32'h1C, d, r, lat);
    checks++;
    if (d !== 32'hAB) begin errors++; $display("FAIL mid_reset_new_write got %h need 000000ab", d); end
    do_read(32'h0C, d, r, lat);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_cleared got %h need 00000000", d); end
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    test_reset();
    test_read_default();
    test_split_write();
    test_strobe();
    test_out_of_range();
    test_zero_strobe();
    test_back_to_back();
    test_collision();
    test_alias();
    test_reset_mid();
    repeat (2) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
